// File: rtl/mem_access_unit.sv
// Load/store initiator: splits one byte/half/word CPU request into big-endian
// single-byte accesses to a byte-wide registered-read memory.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_STORE     = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_LOAD_LAST = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    localparam int unsigned HALF_WIDTH = 2 * WORD_SIZE;

    logic [2:0]            state, state_nxt;
    logic [1:0]            cnt, cnt_nxt;
    logic [1:0]            last, last_nxt;
    logic                  sgn, sgn_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic                  mem_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [WORD_SIZE-1:0]  mem_wdata_nxt;
    logic                  resp_valid_nxt;
    logic                  resp_err_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_nxt;

    logic                  req_err_c;
    logic [1:0]            req_last_c;
    logic [DATA_WIDTH-1:0] req_wdata_left_c;
    logic [DATA_WIDTH-1:0] load_word_c;
    logic [DATA_WIDTH-1:0] load_ext_c;

    assign req_ready = (state == S_IDLE) && !rst;

    // Request decode: byte count, alignment check, store data left-justified
    always_comb begin
        req_last_c       = 2'd0;
        req_err_c        = 1'b0;
        req_wdata_left_c = req_wdata;
        case (req_size)
            2'b00: begin
                req_last_c       = 2'd0;
                req_wdata_left_c = {req_wdata[WORD_SIZE-1:0], {(DATA_WIDTH-WORD_SIZE){1'b0}}};
            end
            2'b01: begin
                req_last_c       = 2'd1;
                req_err_c        = req_addr[0];
                req_wdata_left_c = {req_wdata[HALF_WIDTH-1:0], {(DATA_WIDTH-HALF_WIDTH){1'b0}}};
            end
            2'b10: begin
                req_last_c = 2'd3;
                req_err_c  = (req_addr[1:0] != 2'b00);
            end
            default: req_err_c = 1'b1;
        endcase
    end

    // Final assembled load value and its sign/zero extension from bit 8N-1
    assign load_word_c = {data_q[DATA_WIDTH-WORD_SIZE-1:0], mem_rdata};

    always_comb begin
        load_ext_c = load_word_c;
        case (last)
            2'd0:    load_ext_c = {{(DATA_WIDTH-WORD_SIZE){sgn & load_word_c[WORD_SIZE-1]}},
                                   load_word_c[WORD_SIZE-1:0]};
            2'd1:    load_ext_c = {{(DATA_WIDTH-HALF_WIDTH){sgn & load_word_c[HALF_WIDTH-1]}},
                                   load_word_c[HALF_WIDTH-1:0]};
            default: load_ext_c = load_word_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            last       <= 2'd0;
            sgn        <= 1'b0;
            data_q     <= '0;
            mem_wr_en  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            sgn        <= sgn_nxt;
            data_q     <= data_nxt;
            mem_wr_en  <= mem_wr_en_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
        end
    end

    // Next state and next registered outputs; data_q shifts out stores, accumulates loads
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_nxt       = last;
        sgn_nxt        = sgn;
        data_nxt       = data_q;
        mem_wr_en_nxt  = 1'b1;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = resp_rdata;

        case (state)
            S_IDLE: begin
                resp_rdata_nxt = '0;
                if (req_valid && req_ready) begin
                    if (req_err_c) begin
                        state_nxt      = S_ERR;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt      = 2'd0;
                        last_nxt     = req_last_c;
                        sgn_nxt      = req_signed;
                        mem_addr_nxt = req_addr;
                        if (req_we) begin
                            state_nxt     = S_STORE;
                            mem_wr_en_nxt = 1'b0;
                            mem_wdata_nxt = req_wdata_left_c[DATA_WIDTH-1 -: WORD_SIZE];
                            data_nxt      = req_wdata_left_c << WORD_SIZE;
                        end else begin
                            state_nxt = S_LOAD;
                            data_nxt  = '0;
                        end
                    end
                end
            end
            S_STORE: begin
                if (cnt == last) begin
                    state_nxt      = S_DONE;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = '0;
                end else begin
                    cnt_nxt       = cnt + 2'd1;
                    mem_addr_nxt  = mem_addr + ADDR_WIDTH'(1);
                    mem_wr_en_nxt = 1'b0;
                    mem_wdata_nxt = data_q[DATA_WIDTH-1 -: WORD_SIZE];
                    data_nxt      = data_q << WORD_SIZE;
                end
            end
            S_LOAD: begin
                if (cnt != 2'd0) begin
                    data_nxt = load_word_c;
                end
                if (cnt == last) begin
                    state_nxt = S_LOAD_LAST;
                end else begin
                    cnt_nxt      = cnt + 2'd1;
                    mem_addr_nxt = mem_addr + ADDR_WIDTH'(1);
                end
            end
            S_LOAD_LAST: begin
                state_nxt      = S_DONE;
                data_nxt       = load_word_c;
                resp_valid_nxt = 1'b1;
                resp_rdata_nxt = load_ext_c;
            end
            S_DONE: begin
                state_nxt      = S_IDLE;
                resp_rdata_nxt = '0;
            end
            S_ERR: begin
                state_nxt      = S_IDLE;
                resp_rdata_nxt = '0;
            end
            default: begin
                state_nxt      = S_IDLE;
                resp_rdata_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic        fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .WORD_SIZE(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Byte memory: writes when control pin is 0, registered read every cycle
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (!mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Reference: applies the request to ref_mem and predicts the response
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input int addr, input logic [31:0] wdata,
                                  output int lat, output logic err, output logic [31:0] rdata,
                                  output int wr_cycles);
        int n;
        longint val;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rdata = 32'h0;
        wr_cycles = 0;
        err = (size == 2'd3) || (addr % n != 0);
        if (err) begin
            lat = 1;
        end else if (we) begin
            lat = n + 1;
            wr_cycles = n;
            for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
        end else begin
            lat = n + 2;
            val = 0;
            for (int i = 0; i < n; i++) val = val * 256 + longint'(ref_mem[addr + i]);
            if (sgn && val >= (64'sd1 <<< (8 * n - 1))) val = val - (64'sd1 <<< (8 * n));
            rdata = 32'(val);
        end
    endfunction

    // One request from an IDLE negedge through its response, with per-cycle checks
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wdata);
        int lat, wr_cycles, cyc, lo, n, t;
        logic err;
        logic [31:0] rdata;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        model(we, size, sgn, int'(addr), wdata, lat, err, rdata, wr_cycles);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; lo = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!mem_wr_en) begin
                check("st_addr", 32'(mem_addr), 32'(8'(addr + 8'(lo))));
                check("st_byte", 32'(mem_wdata), (wdata >> (8 * (n - 1 - lo))) & 32'hFF);
                lo++;
            end
            if (!resp_valid && cyc > 1) check("busy_ready", 32'(req_ready), 32'd0);
        end while (!resp_valid && cyc < 12);
        check("latency", 32'(cyc), 32'(lat));
        check("resp_err", 32'(resp_err), 32'(err));
        check("resp_rdata", resp_rdata, rdata);
        check("wr_cycles", 32'(lo), 32'(wr_cycles));
        check("mem_image", 32'(mem_diffs()), 32'd0);
        @(negedge clk);
        check("pulse_end", {31'h0, resp_valid}, 32'd0);
        check("idle_rdata", resp_rdata, 32'h0);
    endtask

    initial begin
        int lat, wrc, acc, rsp, rdy;
        logic err;
        logic [31:0] rd;
        logic [1:0] sz;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        fill = 1'b1;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 8'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        fill = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 8'h12, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 8'h12, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 8'h11, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 8'h12, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 8'h10, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 8'h13, 32'h1234);
        do_req(1'b1, 2'd2, 1'b0, 8'hFC, 32'h89ABCDEF);
        do_req(1'b0, 2'd2, 1'b1, 8'hFC, 32'h0);

        // Reset during a word store: only the first byte lands
        req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 8'h20;
        req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_mem[8'h20] = 8'h11;
        @(negedge clk);
        check("midrst_wr_en", 32'(mem_wr_en), 32'd1);
        check("midrst_resp", 32'(resp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        rsp = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) rsp++;
            @(negedge clk);
        end
        check("midrst_no_resp", 32'(rsp), 32'd0);
        check("midrst_mem", 32'(mem_diffs()), 32'd0);

        // Continuous req_valid: byte load cycles IDLE,LOAD,LOAD_LAST,DONE
        model(1'b0, 2'd0, 1'b1, 8'h12, 32'h0, lat, err, rd, wrc);
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b1; req_addr = 8'h12; req_valid = 1'b1;
        acc = 0; rsp = 0; rdy = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin rdy++; acc++; end
            if (resp_valid) begin
                rsp++;
                check("hold_ready_in_resp", 32'(req_ready), 32'd0);
                check("hold_rdata", resp_rdata, rd);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("hold_accepts", 32'(acc), 32'd10);
        check("hold_responses", 32'(rsp), 32'(acc));

        for (int k = 0; k < 60; k++) begin
            sz = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
